// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying a data/address/control payload.
// The master drives the payload and valid; the slave drives ready.
interface pipe_stage_skid_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CTRL_W = 4
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic [CTRL_W-1:0] ctrl;

    modport master (
        output valid,
        output data,
        output addr,
        output ctrl,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  addr,
        input  ctrl,
        output ready
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer, synchronous flush and
// control-bit masking so that a bubble never asserts a downstream enable.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CTRL_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    pipe_stage_skid_if.slave    in_bus,
    pipe_stage_skid_if.master   out_bus,
    output logic [1:0]          count
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e            state_q;
    logic              main_valid_q;
    logic              in_ready_q;
    logic [1:0]        count_q;

    logic [DATA_W-1:0] main_data_q;
    logic [ADDR_W-1:0] main_addr_q;
    logic [CTRL_W-1:0] main_ctrl_q;

    logic [DATA_W-1:0] skid_data_q;
    logic [ADDR_W-1:0] skid_addr_q;
    logic [CTRL_W-1:0] skid_ctrl_q;

    logic              accept;
    logic              take;

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
    assign accept = in_bus.valid & in_ready_q;
    assign take   = main_valid_q & out_bus.ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StEmpty;
            main_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            count_q      <= 2'd0;
            main_data_q  <= '0;
            main_addr_q  <= '0;
            main_ctrl_q  <= '0;
            skid_data_q  <= '0;
            skid_addr_q  <= '0;
            skid_ctrl_q  <= '0;
        end else if (flush) begin
            // Payloads keep stale contents; masking hides main_ctrl_q.
            state_q      <= StEmpty;
            main_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            count_q      <= 2'd0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_data_q  <= in_bus.data;
                        main_addr_q  <= in_bus.addr;
                        main_ctrl_q  <= in_bus.ctrl;
                        main_valid_q <= 1'b1;
                        count_q      <= 2'd1;
                        state_q      <= StOne;
                    end
                end

                StOne: begin
                    if (accept && take) begin
                        main_data_q <= in_bus.data;
                        main_addr_q <= in_bus.addr;
                        main_ctrl_q <= in_bus.ctrl;
                    end else if (accept) begin
                        skid_data_q <= in_bus.data;
                        skid_addr_q <= in_bus.addr;
                        skid_ctrl_q <= in_bus.ctrl;
                        in_ready_q  <= 1'b0;
                        count_q     <= 2'd2;
                        state_q     <= StFull;
                    end else if (take) begin
                        main_valid_q <= 1'b0;
                        count_q      <= 2'd0;
                        state_q      <= StEmpty;
                    end
                end

                StFull: begin
                    // Upstream is stalled here, so only a downstream take moves state.
                    if (take) begin
                        main_data_q <= skid_data_q;
                        main_addr_q <= skid_addr_q;
                        main_ctrl_q <= skid_ctrl_q;
                        in_ready_q  <= 1'b1;
                        count_q     <= 2'd1;
                        state_q     <= StOne;
                    end
                end

                default: begin
                    state_q      <= StEmpty;
                    main_valid_q <= 1'b0;
                    in_ready_q   <= 1'b1;
                    count_q      <= 2'd0;
                end
            endcase
        end
    end

    assign in_bus.ready  = in_ready_q;
    assign out_bus.valid = main_valid_q;
    assign out_bus.data  = main_data_q;
    assign out_bus.addr  = main_addr_q;
    assign out_bus.ctrl  = main_ctrl_q & {CTRL_W{main_valid_q}};
    assign count         = count_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomised checks for pipe_stage_skid: reset, streaming,
// stall/skid ordering, flush, bubble masking and a scoreboarded soak.
module tb_pipe_stage_skid;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CTRL_W = 4;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [1:0] count;

    int checks;
    int errors;

    pipe_stage_skid_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) in_if ();
    pipe_stage_skid_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) out_if ();

    pipe_stage_skid #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .in_bus  (in_if),
        .out_bus (out_if),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] c);
        in_if.valid = v;
        in_if.data  = d;
        in_if.addr  = d[3:0];
        in_if.ctrl  = c;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        flush = 1'b0;
        out_if.ready = 1'b0;
        drive(1'b1, 32'hAA, 4'h5);
        step();
        step();
        checks++;
        if (out_if.valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %0b expected 0", out_if.valid);
        end
        checks++;
        if (out_if.ctrl !== 4'h0) begin
            errors++; $display("FAIL reset_ctrl: got %0h expected 0", out_if.ctrl);
        end
        checks++;
        if (count !== 2'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", count);
        end
        checks++;
        if (in_if.ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_if.ready);
        end
        reset = 1'b1;
        step();
        checks++;
        if (count !== 2'd1 || out_if.data !== 32'hAA || out_if.ctrl !== 4'h5) begin
            errors++;
            $display("FAIL reset_release: got count=%0d data=%0h ctrl=%0h expected 1 aa 5",
                     count, out_if.data, out_if.ctrl);
        end
        // Asynchronous assertion mid-cycle.
        drive(1'b0, 32'h0, 4'h0);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (count !== 2'd0 || out_if.valid !== 1'b0 || out_if.ctrl !== 4'h0) begin
            errors++;
            $display("FAIL async_reset: got count=%0d valid=%0b ctrl=%0h expected 0 0 0",
                     count, out_if.valid, out_if.ctrl);
        end
        #1 reset = 1'b1;
        step();
    endtask

    task automatic test_streaming;
        out_if.ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 4'(i));
            step();
            checks++;
            if (out_if.valid !== 1'b1 || out_if.data !== 32'(i) || count !== 2'd1) begin
                errors++;
                $display("FAIL stream_%0d: got valid=%0b data=%0h count=%0d expected 1 %0h 1",
                         i, out_if.valid, out_if.data, count, i);
            end
        end
        drive(1'b0, 32'h0, 4'h0);
        step();
        checks++;
        if (count !== 2'd0 || out_if.valid !== 1'b0) begin
            errors++; $display("FAIL stream_drain: got count=%0d expected 0", count);
        end
    endtask

    task automatic test_stall;
        out_if.ready = 1'b0;
        drive(1'b1, 32'h10, 4'h1);
        step();
        drive(1'b1, 32'h20, 4'h2);
        step();
        checks++;
        if (count !== 2'd2 || in_if.ready !== 1'b0 || out_if.data !== 32'h10) begin
            errors++;
            $display("FAIL stall_full: got count=%0d in_ready=%0b data=%0h expected 2 0 10",
                     count, in_if.ready, out_if.data);
        end
        drive(1'b1, 32'h30, 4'h3);
        step();
        checks++;
        if (count !== 2'd2 || out_if.data !== 32'h10) begin
            errors++;
            $display("FAIL stall_reject: got count=%0d data=%0h expected 2 10",
                     count, out_if.data);
        end
        out_if.ready = 1'b1;
        step();
        checks++;
        if (out_if.data !== 32'h20 || count !== 2'd1) begin
            errors++;
            $display("FAIL stall_b: got data=%0h count=%0d expected 20 1", out_if.data, count);
        end
        step();
        checks++;
        if (out_if.data !== 32'h30 || count !== 2'd1) begin
            errors++;
            $display("FAIL stall_c: got data=%0h count=%0d expected 30 1", out_if.data, count);
        end
        drive(1'b0, 32'h0, 4'h0);
        step();
        checks++;
        if (count !== 2'd0 || out_if.valid !== 1'b0) begin
            errors++; $display("FAIL stall_drain: got count=%0d expected 0", count);
        end
    endtask

    task automatic test_flush;
        out_if.ready = 1'b0;
        drive(1'b1, 32'h40, 4'h4);
        step();
        drive(1'b1, 32'h50, 4'h5);
        step();
        flush = 1'b1;
        drive(1'b1, 32'h60, 4'hF);
        step();
        checks++;
        if (count !== 2'd0 || out_if.valid !== 1'b0 || out_if.ctrl !== 4'h0 ||
            in_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: got count=%0d valid=%0b ctrl=%0h rdy=%0b expected 0 0 0 1",
                     count, out_if.valid, out_if.ctrl, in_if.ready);
        end
        // Flush while an accept is possible must discard that entry.
        flush = 1'b0;
        drive(1'b1, 32'h70, 4'h7);
        step();
        flush = 1'b1;
        drive(1'b1, 32'h80, 4'hF);
        step();
        checks++;
        if (count !== 2'd0 || out_if.valid !== 1'b0 || out_if.ctrl !== 4'h0) begin
            errors++;
            $display("FAIL flush_accept: got count=%0d valid=%0b ctrl=%0h expected 0 0 0",
                     count, out_if.valid, out_if.ctrl);
        end
        flush = 1'b0;
        drive(1'b0, 32'h0, 4'h0);
        out_if.ready = 1'b1;
        step();
        checks++;
        if (out_if.valid !== 1'b0 || count !== 2'd0) begin
            errors++;
            $display("FAIL flush_ghost: got valid=%0b count=%0d expected 0 0",
                     out_if.valid, count);
        end
    endtask

    task automatic test_bubble_mask;
        out_if.ready = 1'b0;
        drive(1'b1, 32'h90, 4'b0110);
        step();
        checks++;
        if (out_if.valid !== 1'b1 || out_if.ctrl !== 4'b0110) begin
            errors++;
            $display("FAIL bubble_hold: got valid=%0b ctrl=%0h expected 1 6",
                     out_if.valid, out_if.ctrl);
        end
        drive(1'b0, 32'h0, 4'h0);
        out_if.ready = 1'b1;
        step();
        checks++;
        if (out_if.valid !== 1'b0 || out_if.ctrl !== 4'b0000) begin
            errors++;
            $display("FAIL bubble_mask: got valid=%0b ctrl=%0h expected 0 0",
                     out_if.valid, out_if.ctrl);
        end
    endtask

    task automatic test_random;
        logic [31:0] q[$];
        logic [31:0] seq;
        logic [31:0] exp;
        seq = 32'h100;
        for (int cyc = 0; cyc < 1040; cyc++) begin
            if (cyc < 1000) drive(1'($urandom_range(0, 1)), seq, seq[7:4]);
            else            drive(1'b0, seq, 4'h0);
            out_if.ready = (cyc < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            checks++;
            if ((count == 2'd2 && in_if.ready !== 1'b0) || count !== 2'(q.size())) begin
                errors++;
                $display("FAIL rand_occupancy cyc %0d: got count=%0d rdy=%0b expected %0d",
                         cyc, count, in_if.ready, q.size());
            end
            if (out_if.valid && out_if.ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_dup cyc %0d: got %0h expected none",
                                       cyc, out_if.data);
                end else begin
                    exp = q.pop_front();
                    if (out_if.data !== exp || out_if.addr !== exp[3:0] ||
                        out_if.ctrl !== exp[7:4]) begin
                        errors++;
                        $display("FAIL rand_order cyc %0d: got %0h/%0h/%0h expected %0h",
                                 cyc, out_if.data, out_if.addr, out_if.ctrl, exp);
                    end
                end
            end
            if (in_if.valid && in_if.ready) begin
                q.push_back(seq);
                seq++;
            end
            step();
        end
        checks++;
        if (q.size() != 0 || count !== 2'd0) begin
            errors++;
            $display("FAIL rand_loss: got %0d left count=%0d expected 0", q.size(), count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        flush = 1'b0;
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_bubble_mask();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush, and control-bit masking.
- Generalises the fixed EX/MEM-style pipe register to any payload width.
- Lets a downstream stall back-pressure the upstream stage without losing data, at full throughput.
- Placed between any two datapath stages (EXE->MEM, MEM->WB, camera-to-core streams).

Parameters:
- DATA_W, 32, width of datapath payload (ALU result, write data, etc.)
- ADDR_W, 4, width of destination register address field
- CTRL_W, 4, width of control flag field (PCSrc, RegWrite, MemToReg, MemWrite, ...)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream offers an entry
- in_ready  out  1  stage can accept an entry this cycle
- in_data  in  DATA_W  payload data
- in_addr  in  ADDR_W  payload destination address
- in_ctrl  in  CTRL_W  payload control flags
- out_valid  out  1  stage presents a valid entry
- out_ready  in  1  downstream accepts the presented entry
- out_data  out  DATA_W  presented data
- out_addr  out  ADDR_W  presented address
- out_ctrl  out  CTRL_W  presented control flags, masked to 0 when out_valid=0
- count  out  2  number of held entries (0..2)

Behaviour:
- Reset (reset=0, asynchronous; all state updates on posedge clk):
  - Both entries are invalid and all payload registers are 0.
  - Outputs: out_valid=0, out_data=0, out_addr=0, out_ctrl=0, count=0, in_ready=1.
- Handshakes:
  - Accept: in_valid & in_ready at posedge.
  - Take: out_valid & out_ready at posedge.
  - in_ready = !skid_valid. It is a registered term, with no combinational path from out_ready.
- Storage:
  - main register drives all out_* ports.
  - skid register holds an overflow entry.
- States (count):
  - EMPTY (0):
    - accept -> ONE, main<=in.
  - ONE (1):
    - accept & take -> ONE, main<=in.
    - accept & !take -> FULL, skid<=in, main unchanged.
    - !accept & take -> EMPTY.
    - neither -> hold.
  - FULL (2), in_ready=0:
    - take -> ONE, main<=skid.
    - no take -> hold.
    - in_valid is ignored.
- Ordering: entries leave in strict arrival order. There is no duplication and no loss.
- Latency and throughput:
  - An entry accepted at edge N is visible on out_* after edge N.
  - Sustained throughput is 1 entry/cycle when out_ready is held high.
- Flush (highest priority over accept and take):
  - Next state is EMPTY.
  - Any same-cycle accept is discarded.
  - Payload registers may retain stale data, but out_ctrl reads 0 because of masking.
- Masking: out_ctrl = main_ctrl & {CTRL_W{out_valid}}. A bubble can never assert a write enable downstream.
- out_data and out_addr are undefined-but-stable when out_valid=0; the bench must not check them.
- Reset asserted mid-operation immediately clears all state regardless of clk.

Test Plan:
- Reset asserted, in_valid=1 -> out_valid=0, out_ctrl=0, count=0, in_ready=1. Releasing reset, then 1 edge -> entry captured, count=1.
- Streaming, out_ready=1, in_data=1..8 on consecutive cycles -> out_data=1..8 on consecutive cycles with 1-cycle latency, count stays 1.
- Stall:
  - Feed A=0x10, then hold out_ready=0 and feed B=0x20 -> count=2, in_ready=0.
  - Offer C=0x30 while full -> C not accepted.
  - Raise out_ready -> outputs A, B, C in order.
- Flush: count=2, flush=1 together with in_valid=1, in_ctrl=4'b1111 -> next cycle count=0, out_valid=0, out_ctrl=0. The flushed-cycle entry never appears.
- Bubble masking: main holds ctrl=4'b0110, downstream takes it, no new input -> out_valid=0, out_ctrl=4'b0000.
- Randomised valid/ready with a scoreboard over 1000 cycles -> zero lost, duplicated or reordered entries, and in_ready is never 1 while count=2.
